// File: rtl/skylark_pkg.sv
// Shared decode-stage types for the skylark core.
// Holds the immediate format encoding used by the immediate generator.
package skylark_pkg;

    localparam int IMM_FMT_W = 3;

    // Codes 6 and 7 are deliberately left undefined; they decode as illegal.
    typedef enum logic [IMM_FMT_W-1:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4,
        IMM_Z = 3'd5
    } imm_fmt_e;

endpackage

// File: rtl/imm_decode.sv
// Combinational RV32I/RV64I immediate decoder (I, S, B, U, J, zimm).
// Ports: fmt (format code), bits_in (instr[31:7]), imm (XLEN result), illegal.
module imm_decode
    import skylark_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [IMM_FMT_W-1:0] fmt,
    input  logic [24:0]          bits_in,
    output logic [XLEN-1:0]      imm,
    output logic                 illegal
);

    // bits_in[k] is instruction bit k+7.
    logic        sgn;
    logic signed [31:0] v;

    assign sgn = bits_in[24];

    always_comb begin
        v       = '0;
        illegal = 1'b0;
        unique case (fmt)
            IMM_I: v = {{20{sgn}}, bits_in[24:13]};
            IMM_S: v = {{20{sgn}}, bits_in[24:18], bits_in[4:0]};
            IMM_B: v = {{20{sgn}}, bits_in[0], bits_in[23:18],
                        bits_in[4:1], 1'b0};
            IMM_U: v = {bits_in[24:5], 12'b0};
            IMM_J: v = {{12{sgn}}, bits_in[12:5], bits_in[13],
                        bits_in[23:14], 1'b0};
            IMM_Z: v = {27'b0, bits_in[12:8]};
            default: illegal = 1'b1;
        endcase
    end

    // Every 32-bit form above has the correct sign in bit 31 (zimm has 0),
    // so a signed resize gives both sign and zero extension to XLEN.
    assign imm = XLEN'(v);

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator with a registered output and a 2-entry skid buffer.
// Ports: clk, reset_n, FlushE; in_valid/in_ready/ImmFormatD/bits_in/TagD in;
//        out_valid/out_ready/ExtImmE/TagE/ImmIllegalE out.
module imm_gen_pipe
    import skylark_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 FlushE,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IMM_FMT_W-1:0] ImmFormatD,
    input  logic [24:0]          bits_in,
    input  logic [TAG_W-1:0]     TagD,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      ExtImmE,
    output logic [TAG_W-1:0]     TagE,
    output logic                 ImmIllegalE
);

    logic [XLEN-1:0]  dec_imm;
    logic             dec_ill;

    logic             skid_full;
    logic [XLEN-1:0]  skid_imm;
    logic [TAG_W-1:0] skid_tag;
    logic             skid_ill;
    logic             rdy_q;

    logic acc, drain, main_free;
    logic valid_d, skid_d;
    logic ld_main_in, ld_main_skid, ld_skid;

    imm_decode #(.XLEN(XLEN)) u_dec (
        .fmt     (ImmFormatD),
        .bits_in (bits_in),
        .imm     (dec_imm),
        .illegal (dec_ill)
    );

    // rdy_q mirrors !skid_full but stays low while in reset, so the
    // block only starts accepting after the first edge post-release.
    assign in_ready  = rdy_q;
    assign acc       = in_valid & rdy_q;
    assign drain     = out_valid & out_ready;
    assign main_free = ~out_valid | drain;

    always_comb begin
        valid_d      = out_valid;
        skid_d       = skid_full;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        if (FlushE) begin
            valid_d = 1'b0;
            skid_d  = 1'b0;
        end else if (main_free) begin
            if (skid_full) begin
                ld_main_skid = 1'b1;
                valid_d      = 1'b1;
                ld_skid      = acc;
                skid_d       = acc;
            end else begin
                ld_main_in = acc;
                valid_d    = acc;
            end
        end else if (acc) begin
            ld_skid = 1'b1;
            skid_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            skid_full <= 1'b0;
            rdy_q     <= 1'b0;
        end else begin
            out_valid <= valid_d;
            skid_full <= skid_d;
            rdy_q     <= ~skid_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ExtImmE     <= '0;
            TagE        <= '0;
            ImmIllegalE <= 1'b0;
            skid_imm    <= '0;
            skid_tag    <= '0;
            skid_ill    <= 1'b0;
        end else begin
            if (ld_main_skid) begin
                ExtImmE     <= skid_imm;
                TagE        <= skid_tag;
                ImmIllegalE <= skid_ill;
            end else if (ld_main_in) begin
                ExtImmE     <= dec_imm;
                TagE        <= TagD;
                ImmIllegalE <= dec_ill;
            end
            if (ld_skid) begin
                skid_imm <= dec_imm;
                skid_tag <= TagD;
                skid_ill <= dec_ill;
            end
        end
    end

endmodule
